// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequencing front end for the 4-bit combinational ALU.
// Accepts 12-bit instructions over valid/ready and holds a small register file.
// LDI completes in one cycle. An ALU op issues registered operands to the ALU,
// then writes the ALU result back on the following edge.
module alu_issue_ctrl #(
  parameter int NREG  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [11:0]      in_instr,
  output logic             in_ready,
  output logic [3:0]       alu_rs,
  output logic [3:0]       alu_rt,
  output logic [2:0]       alu_sel,
  input  logic [3:0]       alu_rd,
  output logic             out_valid,
  output logic [1:0]       out_addr,
  output logic [3:0]       out_data,
  output logic [CNT_W-1:0] instr_cnt,
  input  logic [1:0]       dbg_addr,
  output logic [3:0]       dbg_data
);

  typedef enum logic {IDLE, EXEC} state_t;

  // Field view of the instruction word. For LDI, imm is {src_t, pad}.
  typedef struct packed {
    logic       ldi;
    logic [2:0] sel;
    logic [1:0] dst;
    logic [1:0] src_s;
    logic [1:0] src_t;
    logic [1:0] pad;
  } instr_t;

  state_t                 state, state_nxt;
  instr_t                 ins;
  logic [NREG-1:0][3:0]   rf;
  logic [1:0]             dst_q;
  logic                   accept;
  logic [3:0]             imm;

  assign ins    = instr_t'(in_instr);
  assign imm    = in_instr[3:0];
  assign accept = in_valid && in_ready;

  // Ready only while idle and out of reset.
  assign in_ready = (state == IDLE) && rst_n;

  // Register reads are combinational, so a pending write is not yet visible.
  assign dbg_data = rf[dbg_addr];

  // Next-state: an accepted ALU op moves to EXEC; EXEC always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !ins.ldi) state_nxt = EXEC;
      EXEC: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, register file, ALU operand latches and completion reporting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rf        <= '0;
      dst_q     <= '0;
      alu_rs    <= '0;
      alu_rt    <= '0;
      alu_sel   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      instr_cnt <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (ins.ldi) begin
              rf[ins.dst] <= imm;
              out_valid   <= 1'b1;
              out_addr    <= ins.dst;
              out_data    <= imm;
              instr_cnt   <= instr_cnt + 1'b1;
            end else begin
              // Operands are captured now, so dst may alias either source.
              alu_rs  <= rf[ins.src_s];
              alu_rt  <= rf[ins.src_t];
              alu_sel <= ins.sel;
              dst_q   <= ins.dst;
            end
          end
        end
        EXEC: begin
          rf[dst_q] <= alu_rd;
          out_valid <= 1'b1;
          out_addr  <= dst_q;
          out_data  <= alu_rd;
          instr_cnt <= instr_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural model of the external ALU.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] in_instr;
  logic        in_ready;
  logic [3:0]  alu_rs, alu_rt, alu_rd;
  logic [2:0]  alu_sel;
  logic        out_valid;
  logic [1:0]  out_addr;
  logic [3:0]  out_data;
  logic [7:0]  instr_cnt;
  logic [1:0]  dbg_addr;
  logic [3:0]  dbg_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.NREG(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_sel(alu_sel),
    .alu_rd(alu_rd), .out_valid(out_valid), .out_addr(out_addr),
    .out_data(out_data), .instr_cnt(instr_cnt), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  // External combinational ALU.
  always_comb begin
    alu_rd = 4'h0;
    case (alu_sel)
      3'b000: alu_rd = alu_rs - alu_rt;
      3'b001: alu_rd = alu_rs + alu_rt;
      3'b010: alu_rd = alu_rs | alu_rt;
      3'b011: alu_rd = alu_rs & alu_rt;
      3'b100: alu_rd = {alu_rt[3], alu_rt[3:1]};
      3'b101: alu_rd = {alu_rs[2:0], alu_rs[3]};
      3'b110: alu_rd = {3'b101, alu_rs < alu_rt};
      3'b111: alu_rd = {3'b111, alu_rs == alu_rt};
      default: alu_rd = 4'h0;
    endcase
  end

  // LDI; returns #1 after the accepting edge.
  task automatic ldi(input logic [1:0] d, input logic [3:0] imm);
    in_valid = 1'b1;
    in_instr = {1'b1, 3'b000, d, 2'b00, imm};
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // ALU op; returns #1 after the write-back edge.
  task automatic op(input logic [2:0] sel, input logic [1:0] d, s, t);
    in_valid = 1'b1;
    in_instr = {1'b0, sel, d, s, t, 2'b00};
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; dbg_addr = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0 || out_addr !== 2'd0 || out_data !== 4'h0) begin n_fail++; $display("FAIL rst_out got %b/%h/%h want 0/0/0", out_valid, out_addr, out_data); end
    n_cmp++; if (instr_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", instr_cnt); end
    n_cmp++; if (alu_rs !== 4'h0 || alu_rt !== 4'h0 || alu_sel !== 3'h0) begin n_fail++; $display("FAIL rst_alu got %h/%h/%h want 0/0/0", alu_rs, alu_rt, alu_sel); end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      n_cmp++; if (dbg_data !== 4'h0) begin n_fail++; $display("FAIL rst_reg%0d got %h want 0", i, dbg_data); end
    end
    rst_n = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready got %b want 1", in_ready); end
  endtask

  task automatic test_ldi;
    ldi(2'd0, 4'd5);
    n_cmp++; if (out_valid !== 1'b1 || out_addr !== 2'd0 || out_data !== 4'd5) begin n_fail++; $display("FAIL ldi0 got %b/%h/%h want 1/0/5", out_valid, out_addr, out_data); end
    ldi(2'd1, 4'd3);
    n_cmp++; if (out_valid !== 1'b1 || out_addr !== 2'd1 || out_data !== 4'd3) begin n_fail++; $display("FAIL ldi1 got %b/%h/%h want 1/1/3", out_valid, out_addr, out_data); end
    n_cmp++; if (instr_cnt !== 8'd2) begin n_fail++; $display("FAIL ldi_cnt got %0d want 2", instr_cnt); end
    dbg_addr = 2'd0; #1;
    n_cmp++; if (dbg_data !== 4'd5) begin n_fail++; $display("FAIL ldi_dbg0 got %h want 5", dbg_data); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ldi_pulse got %b want 0", out_valid); end
  endtask

  task automatic test_sub_add;
    // SUB r2 = r0 - r1, observing the EXEC cycle explicitly
    in_valid = 1'b1;
    in_instr = {1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 2'b00};
    @(posedge clk); #1;
    in_valid = 1'b0; dbg_addr = 2'd2; #1;
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL exec_hs got rdy %b ov %b want 0/0", in_ready, out_valid); end
    n_cmp++; if (alu_rs !== 4'd5 || alu_rt !== 4'd3 || alu_sel !== 3'd0) begin n_fail++; $display("FAIL exec_alu got %h/%h/%h want 5/3/0", alu_rs, alu_rt, alu_sel); end
    n_cmp++; if (dbg_data !== 4'h0) begin n_fail++; $display("FAIL exec_prewrite got %h want 0", dbg_data); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_addr !== 2'd2 || out_data !== 4'd2) begin n_fail++; $display("FAIL sub got %b/%h/%h want 1/2/2", out_valid, out_addr, out_data); end
    n_cmp++; if (in_ready !== 1'b1 || instr_cnt !== 8'd3) begin n_fail++; $display("FAIL sub_post got rdy %b cnt %0d want 1/3", in_ready, instr_cnt); end
    n_cmp++; if (dbg_data !== 4'd2) begin n_fail++; $display("FAIL sub_reg got %h want 2", dbg_data); end
    ldi(2'd0, 4'd9); ldi(2'd1, 4'd9);
    op(3'b001, 2'd2, 2'd0, 2'd1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'h2) begin n_fail++; $display("FAIL add_wrap got %b/%h want 1/2", out_valid, out_data); end
    n_cmp++; if (instr_cnt !== 8'd6) begin n_fail++; $display("FAIL add_cnt got %0d want 6", instr_cnt); end
  endtask

  task automatic test_compare;
    ldi(2'd0, 4'd3); ldi(2'd1, 4'd5);
    op(3'b110, 2'd2, 2'd0, 2'd1);
    n_cmp++; if (out_data !== 4'b1011) begin n_fail++; $display("FAIL slt_lt got %b want 1011", out_data); end
    op(3'b110, 2'd2, 2'd1, 2'd0);
    n_cmp++; if (out_data !== 4'b1010) begin n_fail++; $display("FAIL slt_ge got %b want 1010", out_data); end
    ldi(2'd0, 4'd7); ldi(2'd1, 4'd7);
    op(3'b111, 2'd3, 2'd0, 2'd1);
    n_cmp++; if (out_data !== 4'b1111 || out_addr !== 2'd3) begin n_fail++; $display("FAIL seq_eq got %b@%0d want 1111@3", out_data, out_addr); end
    ldi(2'd1, 4'd6);
    op(3'b111, 2'd3, 2'd0, 2'd1);
    n_cmp++; if (out_data !== 4'b1110) begin n_fail++; $display("FAIL seq_ne got %b want 1110", out_data); end
  endtask

  task automatic test_shift;
    ldi(2'd1, 4'b1000);
    op(3'b100, 2'd2, 2'd0, 2'd1);
    n_cmp++; if (out_data !== 4'b1100) begin n_fail++; $display("FAIL sra got %b want 1100", out_data); end
    ldi(2'd0, 4'b1001);
    op(3'b101, 2'd2, 2'd0, 2'd1);
    n_cmp++; if (out_data !== 4'b0011) begin n_fail++; $display("FAIL rol got %b want 0011", out_data); end
    ldi(2'd3, 4'd6);
    op(3'b001, 2'd3, 2'd3, 2'd3);
    dbg_addr = 2'd3; #1;
    n_cmp++; if (out_data !== 4'hC || dbg_data !== 4'hC) begin n_fail++; $display("FAIL alias got %h reg %h want C/C", out_data, dbg_data); end
  endtask

  // r0=9, r1=8 on entry. Three ops with in_valid held high.
  task automatic test_back_to_back;
    logic [11:0] prog [3];
    logic [1:0]  eaddr [3];
    logic [3:0]  edata [3];
    logic [7:0]  cnt0;
    prog[0] = {1'b0, 3'b010, 2'd2, 2'd0, 2'd1, 2'b00}; eaddr[0] = 2'd2; edata[0] = 4'd9;
    prog[1] = {1'b0, 3'b011, 2'd3, 2'd0, 2'd1, 2'b00}; eaddr[1] = 2'd3; edata[1] = 4'd8;
    prog[2] = {1'b0, 3'b000, 2'd0, 2'd0, 2'd1, 2'b00}; eaddr[2] = 2'd0; edata[2] = 4'd1;
    cnt0 = instr_cnt;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_instr = prog[k];
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_issue%0d got ov %b rdy %b want 0/0", k, out_valid, in_ready); end
      if (k == 2) in_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || out_addr !== eaddr[k] || out_data !== edata[k]) begin n_fail++; $display("FAIL b2b_wb%0d got %b/%h/%h want 1/%h/%h", k, out_valid, out_addr, out_data, eaddr[k], edata[k]); end
    end
    n_cmp++; if (instr_cnt !== 8'(cnt0 + 8'd3)) begin n_fail++; $display("FAIL b2b_cnt got %0d want %0d", instr_cnt, 8'(cnt0 + 8'd3)); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got ov %b rdy %b want 0/1", out_valid, in_ready); end
  endtask

  // r0=1, r1=8: reset lands in the EXEC cycle of r2=r0+r1.
  task automatic test_reset_exec;
    in_valid = 1'b1;
    in_instr = {1'b0, 3'b001, 2'd2, 2'd0, 2'd1, 2'b00};
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    dbg_addr = 2'd2; #1;
    n_cmp++; if (out_valid !== 1'b0 || out_addr !== 2'd0 || out_data !== 4'h0) begin n_fail++; $display("FAIL rexec_out got %b/%h/%h want 0/0/0", out_valid, out_addr, out_data); end
    n_cmp++; if (dbg_data !== 4'h0 || instr_cnt !== 8'd0) begin n_fail++; $display("FAIL rexec_state got reg %h cnt %0d want 0/0", dbg_data, instr_cnt); end
    n_cmp++; if (alu_rs !== 4'h0 || alu_rt !== 4'h0 || alu_sel !== 3'h0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rexec_alu got %h/%h/%h rdy %b want 0/0/0/0", alu_rs, alu_rt, alu_sel, in_ready); end
    rst_n = 1'b1; #1;
    ldi(2'd1, 4'd4);
    n_cmp++; if (out_valid !== 1'b1 || out_addr !== 2'd1 || out_data !== 4'd4 || instr_cnt !== 8'd1) begin n_fail++; $display("FAIL rexec_ldi got %b/%h/%h cnt %0d want 1/1/4/1", out_valid, out_addr, out_data, instr_cnt); end
  endtask

  // Starts with instr_cnt = 1.
  task automatic test_cnt_wrap;
    for (int i = 0; i < 254; i++) ldi(2'(i), 4'(i));
    n_cmp++; if (instr_cnt !== 8'd255) begin n_fail++; $display("FAIL cnt_max got %0d want 255", instr_cnt); end
    ldi(2'd0, 4'hF);
    n_cmp++; if (instr_cnt !== 8'd0) begin n_fail++; $display("FAIL cnt_wrap got %0d want 0", instr_cnt); end
  endtask

  initial begin
    test_reset;
    test_ldi;
    test_sub_add;
    test_compare;
    test_shift;
    test_back_to_back;
    test_reset_exec;
    test_cnt_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
